// File: rtl/irq_region_guard.sv
`default_nettype none
// ============================================================================
// Module      : irq_region_guard
// Description : Kills the core when an interrupt is taken inside, or a DMA
//               access lands in, a protected region; logs cause and count.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_region_guard #(
    parameter int                 NREG          = 2,
    // Region 0 is A000..A7FF, region 1 is E000..EFFF
    parameter logic [16*NREG-1:0] REG_BASE      = {16'hE000, 16'hA000},
    parameter logic [16*NREG-1:0] REG_SIZE      = {16'h1000, 16'h0800},
    parameter logic [NREG-1:0]    IRQ_OK        = '0,
    parameter bit                 DMA_CHECK     = 1'b1,
    parameter int                 HOLD_CYCLES   = 4,
    parameter logic [15:0]        RESET_HANDLER = 16'h0000,
    parameter int                 CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         pc,
    input  logic                irq,
    input  logic                dma_en,
    input  logic [15:0]         dma_addr,
    output logic                reset,
    output logic [2*NREG-1:0]   cause,
    output logic [CNT_W-1:0]    viol_cnt
);

    localparam int              HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   C_HLOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]   C_HONE  = HW'(1);
    localparam logic [CNT_W-1:0] C_CONE = CNT_W'(1);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_KILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [NREG-1:0]   w_irq_v;
    logic [NREG-1:0]   w_dma_v;
    logic [2*NREG-1:0] w_cvec;
    logic              w_viol;

    for (genvar i = 0; i < NREG; i++) begin : g_region
        localparam logic [15:0] BASE = REG_BASE[16*i +: 16];
        localparam logic [15:0] SIZE = REG_SIZE[16*i +: 16];
        // 17-bit end address so a region finishing at FFFF does not wrap
        localparam logic [16:0] END1 = {1'b0, BASE} + {1'b0, SIZE};
        localparam logic [16:0] LAST = END1 - 17'd1;

        if (END1 > 17'h10000) begin : g_cfg_err
            $error("irq_region_guard: region %0d exceeds the 64 KiB address space", i);
        end

        logic w_in_pc;
        logic w_in_dma;
        assign w_in_pc  = (SIZE != 16'd0) && (pc >= BASE) && ({1'b0, pc} <= LAST);
        assign w_in_dma = (SIZE != 16'd0) && (dma_addr >= BASE) && ({1'b0, dma_addr} <= LAST);

        assign w_irq_v[i]      = irq && w_in_pc && !IRQ_OK[i];
        assign w_dma_v[i]      = DMA_CHECK && dma_en && w_in_dma;
        assign w_cvec[2*i]     = w_irq_v[i];
        assign w_cvec[2*i + 1] = w_dma_v[i];
    end

    assign w_viol = |w_cvec;

    logic [1:0]        state_q, state_d;
    logic [HW-1:0]     hcnt_q,  hcnt_d;
    logic [2*NREG-1:0] cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              reset_q;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (w_viol) begin
                    hcnt_d = C_HLOAD;
                end else if (hcnt_q == '0) begin
                    state_d = ST_KILL;
                end else begin
                    hcnt_d = hcnt_q - C_HONE;
                end
            end
            ST_KILL: begin
                if ((pc == RESET_HANDLER) && !w_viol) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Only the first violation out of RUN is logged
                if (w_viol) begin
                    state_d = ST_HOLD;
                    hcnt_d  = C_HLOAD;
                    cause_d = w_cvec;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + C_CONE;
                    end
                end
            end
            default: begin
                state_d = ST_HOLD;
                hcnt_d  = C_HLOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HOLD;
            hcnt_q  <= C_HLOAD;
            cause_q <= '0;
            cnt_q   <= '0;
            reset_q <= 1'b1;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            reset_q <= (state_d != ST_RUN);
        end
    end

    assign reset    = reset_q;
    assign cause    = cause_q;
    assign viol_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_region_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_region_guard
// Description : Scoreboard bench for irq_region_guard (default, IRQ_OK and
//               narrow-counter configurations side by side).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_region_guard;

    typedef struct packed {
        logic       rs;
        logic [3:0] ca;
        logic [7:0] cn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = 16'h0;
    logic        irq = 1'b0;
    logic        dma_en = 1'b0;
    logic [15:0] dma_addr = 16'h0;

    logic       reset_a, reset_b, reset_c;
    logic [3:0] cause_a, cause_b, cause_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t e, o;

    always #5 clk = ~clk;

    irq_region_guard u_def (
        .clk(clk), .rst(rst), .pc(pc), .irq(irq), .dma_en(dma_en),
        .dma_addr(dma_addr), .reset(reset_a), .cause(cause_a), .viol_cnt(cnt_a)
    );

    irq_region_guard #(.IRQ_OK(2'b10)) u_ok (
        .clk(clk), .rst(rst), .pc(pc), .irq(irq), .dma_en(dma_en),
        .dma_addr(dma_addr), .reset(reset_b), .cause(cause_b), .viol_cnt(cnt_b)
    );

    irq_region_guard #(.CNT_W(2)) u_cnt (
        .clk(clk), .rst(rst), .pc(pc), .irq(irq), .dma_en(dma_en),
        .dma_addr(dma_addr), .reset(reset_c), .cause(cause_c), .viol_cnt(cnt_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst();
        rst = 1'b1; irq = 1'b0; dma_en = 1'b0; pc = 16'h0; dma_addr = 16'h0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = 1'b0; dma_en = 1'b0; pc = 16'h0;
        sb.push_back('{1'b1, 4'd0, 8'd0});
        tick();
        rst = 1'b0;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_state: got %h exp %h", o, e); end
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{(k < 5), 4'd0, 8'd0});
            tick();
            e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL reset_seq[%0d]: got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_irq_viol();
        apply_rst();
        pc = 16'hE010; irq = 1'b1;
        sb.push_back('{1'b1, 4'b0100, 8'd1});
        tick();
        irq = 1'b0; pc = 16'h0;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL irq_viol: got %h exp %h", o, e); end
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{(k < 5), 4'b0100, 8'd1});
            tick();
            e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL irq_recover[%0d]: got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_dma();
        apply_rst();
        dma_en = 1'b1; dma_addr = 16'hA7FF;
        sb.push_back('{1'b1, 4'b0010, 8'd1});
        tick();
        dma_en = 1'b0;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL dma_last: got %h exp %h", o, e); end
        repeat (4) tick();
        sb.push_back('{1'b0, 4'b0010, 8'd1});
        tick();
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL dma_recover: got %h exp %h", o, e); end
        dma_en = 1'b1; dma_addr = 16'hA800;
        sb.push_back('{1'b0, 4'b0010, 8'd1});
        tick();
        dma_en = 1'b0;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL dma_last_plus1: got %h exp %h", o, e); end
        // Simultaneous IRQ (region 1) and DMA (region 0) count once
        pc = 16'hE010; irq = 1'b1; dma_en = 1'b1; dma_addr = 16'hA000;
        sb.push_back('{1'b1, 4'b0110, 8'd2});
        tick();
        irq = 1'b0; dma_en = 1'b0; pc = 16'h0;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL irq_dma_same: got %h exp %h", o, e); end
    endtask

    task automatic test_irq_ok();
        apply_rst();
        irq = 1'b1; pc = 16'hEFFF;
        sb.push_back('{1'b0, 4'b0000, 8'd0});
        sb.push_back('{1'b1, 4'b0100, 8'd1});
        tick();
        e = sb.pop_front(); o = {reset_b, cause_b, cnt_b}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL irqok_permitted: got %h exp %h", o, e); end
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL def_region1_last: got %h exp %h", o, e); end
        pc = 16'hDFFF;
        sb.push_back('{1'b0, 4'b0000, 8'd0});
        tick();
        e = sb.pop_front(); o = {reset_b, cause_b, cnt_b}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL irqok_outside: got %h exp %h", o, e); end
        pc = 16'hA000;
        sb.push_back('{1'b1, 4'b0001, 8'd1});
        tick();
        irq = 1'b0; pc = 16'h0;
        e = sb.pop_front(); o = {reset_b, cause_b, cnt_b}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL irqok_region0: got %h exp %h", o, e); end
    endtask

    task automatic test_hold_extend();
        apply_rst();
        pc = 16'hE010; irq = 1'b1;
        sb.push_back('{1'b1, 4'b0100, 8'd1});
        tick();
        irq = 1'b0; pc = 16'h0;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL hold_entry: got %h exp %h", o, e); end
        for (int i = 0; i < 10; i++) begin
            dma_en = (i % 2 == 0); dma_addr = 16'hA000;
            sb.push_back('{1'b1, 4'b0100, 8'd1});
            tick();
            e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL hold_reviol[%0d]: got %h exp %h", i, o, e); end
        end
        dma_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{(k != 3), 4'b0100, 8'd1});
            tick();
            e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL hold_drain[%0d]: got %h exp %h", k, o, e); end
        end
        pc = 16'hE010; irq = 1'b1;
        tick();
        irq = 1'b0; pc = 16'h1234;
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{1'b1, 4'b0100, 8'd2});
            tick();
            e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL kill_stay[%0d]: got %h exp %h", k, o, e); end
        end
        // Handler reached but a violation in the same cycle must block exit
        pc = 16'h0; dma_en = 1'b1; dma_addr = 16'hA000;
        sb.push_back('{1'b1, 4'b0100, 8'd2});
        tick();
        dma_en = 1'b0; pc = 16'h1234;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL kill_viol_at_handler: got %h exp %h", o, e); end
        rst = 1'b1;
        sb.push_back('{1'b1, 4'b0000, 8'd0});
        tick();
        rst = 1'b0; pc = 16'h0;
        e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL rst_mid_kill: got %h exp %h", o, e); end
        for (int k = 1; k <= 5; k++) begin
            sb.push_back('{(k < 5), 4'b0000, 8'd0});
            tick();
            e = sb.pop_front(); o = {reset_a, cause_a, cnt_a}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL rst_restart[%0d]: got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_saturate();
        apply_rst();
        for (int v = 1; v <= 5; v++) begin
            pc = 16'hE010; irq = 1'b1;
            sb.push_back('{1'b1, 4'b0100, 8'((v > 3) ? 3 : v)});
            tick();
            irq = 1'b0; pc = 16'h0;
            e = sb.pop_front(); o = {reset_c, cause_c, 6'd0, cnt_c}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL sat_cnt[%0d]: got %h exp %h", v, o, e); end
            repeat (4) tick();
            sb.push_back('{1'b0, 4'b0100, 8'((v > 3) ? 3 : v)});
            tick();
            e = sb.pop_front(); o = {reset_c, cause_c, 6'd0, cnt_c}; n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL sat_recover[%0d]: got %h exp %h", v, o, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_irq_viol();
        test_dma();
        test_irq_ok();
        test_hold_extend();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
